// File: rtl/axin_drop_fifo.sv
// axin_drop_fifo: single-clock store-and-forward packet FIFO; drops aborted and oversize packets.
// Define AXIN_DROP_STATS_EN to add the o_aborts / o_overflows saturating counters.
module axin_drop_fifo #(
  parameter  int DW     = 32,
  parameter  int LGFIFO = 5,
  localparam int BW     = $clog2(DW/8)
) (
  input  logic          S_CLK,
  input  logic          S_ARESETN,
  input  logic          S_VALID,
  output logic          S_READY,
  input  logic [DW-1:0] S_DATA,
  input  logic [BW-1:0] S_BYTES,
  input  logic          S_ABORT,
  input  logic          S_LAST,
  output logic          M_VALID,
  input  logic          M_READY,
  output logic [DW-1:0] M_DATA,
  output logic [BW-1:0] M_BYTES,
  output logic          M_LAST
`ifdef AXIN_DROP_STATS_EN
  ,
  output logic [15:0]   o_aborts,
  output logic [15:0]   o_overflows
`endif
);

  localparam int PW    = LGFIFO + 1;
  localparam int DEPTH = 1 << LGFIFO;
  localparam int EW    = 1 + BW + DW;

  // ST_IDLE   | no packet in progress, wr_q == commit_q
  // ST_MIDPKT | at least one beat of the current packet is stored
  // ST_DROP   | swallowing the remainder of a packet that can never fit
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MIDPKT = 2'd1,
    ST_DROP   = 2'd2
  } wr_state_e;

  wr_state_e       state_q, state_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   commit_q, commit_d;
  logic [PW-1:0]   rd_q;
  logic [PW-1:0]   fill;
  logic [EW-1:0]   mem_q [DEPTH];

  logic            full;
  logic            oversize;
  logic            beat_acc;
  logic            abort_ev;
  logic            mem_we;
  logic            abort_inc;
  logic            ovf_inc;
  logic            rd_load;

  logic            m_valid_q;
  logic            m_last_q;
  logic [BW-1:0]   m_bytes_q;
  logic [DW-1:0]   m_data_q;

  assign fill     = wr_q - rd_q;
  assign full     = (fill == PW'(DEPTH));
  // The whole buffer holds only the open packet and it still is not finished.
  assign oversize = (state_q == ST_MIDPKT) && full && (commit_q == rd_q);

  assign S_READY  = !S_ARESETN || S_ABORT || (state_q == ST_DROP) || oversize || !full;
  assign beat_acc = S_VALID && S_READY && !S_ABORT;
  assign abort_ev = S_ABORT && (!S_VALID || S_READY);

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    commit_d  = commit_q;
    mem_we    = 1'b0;
    abort_inc = 1'b0;
    ovf_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (beat_acc) begin
          mem_we = 1'b1;
          wr_d   = wr_q + PW'(1);
          if (S_LAST) commit_d = wr_q + PW'(1);
          else        state_d  = ST_MIDPKT;
        end
      end
      ST_MIDPKT: begin
        if (abort_ev) begin
          wr_d      = commit_q;
          abort_inc = 1'b1;
          state_d   = ST_IDLE;
        end else if (oversize) begin
          // The beat on offer this cycle is swallowed as the first dropped beat.
          wr_d    = commit_q;
          ovf_inc = 1'b1;
          state_d = (beat_acc && S_LAST) ? ST_IDLE : ST_DROP;
        end else if (beat_acc) begin
          mem_we = 1'b1;
          wr_d   = wr_q + PW'(1);
          if (S_LAST) begin
            commit_d = wr_q + PW'(1);
            state_d  = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (abort_ev || (beat_acc && S_LAST)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge S_CLK) begin
    if (!S_ARESETN) begin
      state_q  <= ST_IDLE;
      wr_q     <= '0;
      commit_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      commit_q <= commit_d;
    end
  end

  always_ff @(posedge S_CLK) begin
    if (mem_we) mem_q[wr_q[LGFIFO-1:0]] <= {S_LAST, S_BYTES, S_DATA};
  end

  assign rd_load = (rd_q != commit_q) && (!m_valid_q || M_READY);

  always_ff @(posedge S_CLK) begin
    if (!S_ARESETN) begin
      rd_q      <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_bytes_q <= '0;
      m_data_q  <= '0;
    end else if (rd_load) begin
      {m_last_q, m_bytes_q, m_data_q} <= mem_q[rd_q[LGFIFO-1:0]];
      rd_q      <= rd_q + PW'(1);
      m_valid_q <= 1'b1;
    end else if (M_READY) begin
      m_valid_q <= 1'b0;
    end
  end

  assign M_VALID = m_valid_q;
  assign M_LAST  = m_last_q;
  assign M_BYTES = m_bytes_q;
  assign M_DATA  = m_data_q;

`ifdef AXIN_DROP_STATS_EN
  logic [15:0] aborts_q;
  logic [15:0] overflows_q;

  always_ff @(posedge S_CLK) begin
    if (!S_ARESETN) begin
      aborts_q    <= '0;
      overflows_q <= '0;
    end else begin
      if (abort_inc && (aborts_q != 16'hFFFF))  aborts_q    <= aborts_q + 16'd1;
      if (ovf_inc && (overflows_q != 16'hFFFF)) overflows_q <= overflows_q + 16'd1;
    end
  end

  assign o_aborts    = aborts_q;
  assign o_overflows = overflows_q;
`else
  logic unused_stats;
  assign unused_stats = abort_inc ^ ovf_inc;
`endif

endmodule

// File: tb/tb_axin_drop_fifo.sv
// tb_axin_drop_fifo: directed and randomized packet traffic against a packet-level scoreboard.
// The model only knows which packets survive (no abort, length <= depth) and their beats in order.
module tb_axin_drop_fifo;
  localparam int DW     = 32;
  localparam int LGFIFO = 4;
  localparam int DEPTH  = 1 << LGFIFO;
  localparam int BW     = $clog2(DW/8);
  localparam int PW     = LGFIFO + 1;

  logic          S_CLK     = 1'b0;
  logic          S_ARESETN = 1'b0;
  logic          S_VALID   = 1'b0;
  logic          S_ABORT   = 1'b0;
  logic          S_LAST    = 1'b0;
  logic          M_READY   = 1'b0;
  logic [DW-1:0] S_DATA    = '0;
  logic [BW-1:0] S_BYTES   = '0;
  logic          S_READY;
  logic          M_VALID;
  logic          M_LAST;
  logic [DW-1:0] M_DATA;
  logic [BW-1:0] M_BYTES;
`ifdef AXIN_DROP_STATS_EN
  logic [15:0]   o_aborts;
  logic [15:0]   o_overflows;
`endif

  axin_drop_fifo #(.DW(DW), .LGFIFO(LGFIFO)) dut (
    .S_CLK(S_CLK), .S_ARESETN(S_ARESETN),
    .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA), .S_BYTES(S_BYTES),
    .S_ABORT(S_ABORT), .S_LAST(S_LAST),
    .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA), .M_BYTES(M_BYTES),
    .M_LAST(M_LAST)
`ifdef AXIN_DROP_STATS_EN
    , .o_aborts(o_aborts), .o_overflows(o_overflows)
`endif
  );

  always #5 S_CLK = ~S_CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int stalls  = 0;
  int rd_mode = 0;
  int exp_aborts = 0;
  int exp_ovf    = 0;
  logic [PW-1:0]   exp_wr = '0;
  logic [DW+BW:0]  exp_q [$];
  logic [DW-1:0]   pd [64];
  logic [BW-1:0]   pb [64];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge S_CLK);
    #1;
  endtask

  // rd_mode: 0 hold M_READY low, 1 hold high, 2 random
  initial forever begin
    @(posedge S_CLK);
    #1;
    case (rd_mode)
      0:       M_READY = 1'b0;
      1:       M_READY = 1'b1;
      default: M_READY = ($urandom_range(3) != 0);
    endcase
  end

  initial forever begin
    logic [35:0] got_v, exp_v;
    @(negedge S_CLK);
    if (S_ARESETN && M_VALID && M_READY) begin
      got_v = {1'b1, M_LAST, M_BYTES, M_DATA};
      if (exp_q.size() != 0) exp_v = {1'b1, exp_q.pop_front()};
      else                   exp_v = '0;
      chk("out_beat", 64'(got_v), 64'(exp_v));
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic [BW-1:0] b,
                           input logic last, input logic abort);
    int guard = 0;
    S_VALID = 1'b1; S_DATA = d; S_BYTES = b; S_LAST = last; S_ABORT = abort;
    @(negedge S_CLK);
    while (!S_READY && guard < 3000) begin
      stalls++;
      guard++;
      @(negedge S_CLK);
    end
    if (guard >= 3000) chk("s_ready_timeout", 64'(S_READY), 64'(1));
    tick();
    S_VALID = 1'b0; S_LAST = 1'b0; S_ABORT = 1'b0;
  endtask

  task automatic send_abort();
    S_ABORT = 1'b1;
    tick();
    S_ABORT = 1'b0;
  endtask

  task automatic fill_rand(input int len);
    for (int i = 0; i < len; i++) begin
      pd[i] = $urandom;
      pb[i] = BW'($urandom_range(DW/8 - 1));
    end
  endtask

  // abort_at < 0: no abort; else abort after abort_at beats (with or without S_VALID)
  task automatic send_pkt(input int len, input int abort_at, input bit abort_valid, input int gap_pct);
    for (int i = 0; i < len; i++) begin
      if (abort_at == i) begin
        if (abort_valid) send_beat(pd[i], pb[i], i == len-1, 1'b1);
        else             send_abort();
        break;
      end
      send_beat(pd[i], pb[i], i == len-1, 1'b0);
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) tick();
    end
    if (abort_at >= 0)      exp_aborts++;
    else if (len > DEPTH)   exp_ovf++;
    else begin
      for (int i = 0; i < len; i++) exp_q.push_back({i == len-1, pb[i], pd[i]});
      exp_wr = exp_wr + PW'(len);
    end
  endtask

  task automatic do_reset(input int cycles);
    S_ARESETN = 1'b0; S_VALID = 1'b0; S_ABORT = 1'b0; S_LAST = 1'b0;
    @(negedge S_CLK);
    chk("ready_in_reset", 64'(S_READY), 64'(1));
    repeat (cycles) tick();
    S_ARESETN = 1'b1;
    exp_q.delete();
    exp_wr = '0; exp_aborts = 0; exp_ovf = 0;
  endtask

  task automatic check_reset_state();
    chk("rst_m_valid", 64'(M_VALID), 64'(0));
    chk("rst_m_fields", 64'({M_LAST, M_BYTES, M_DATA}), 64'(0));
    chk("rst_ptrs", 64'({dut.wr_q, dut.commit_q, dut.rd_q}), 64'(0));
    chk("rst_s_ready", 64'(S_READY), 64'(1));
  endtask

  task automatic drain(input string tag);
    int g = 0;
    rd_mode = 1;
    while (exp_q.size() != 0 && g < 2000) begin
      tick();
      g++;
    end
    repeat (6) tick();
    chk(tag, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic check_stats(input string tag);
`ifdef AXIN_DROP_STATS_EN
    chk({tag, "_aborts"},    64'(o_aborts),    64'(exp_aborts));
    chk({tag, "_overflows"}, 64'(o_overflows), 64'(exp_ovf));
`else
    chk({tag, "_wr_ptr"}, 64'(dut.wr_q), 64'(exp_wr));
`endif
  endtask

  initial begin
    int s_first, s_third;

    do_reset(3);
    check_reset_state();

    // latency and back-to-back streaming
    rd_mode = 1;
    tick();
    pd[0] = 32'hA0; pd[1] = 32'hA1; pd[2] = 32'hA2;
    pb[0] = 2'd0;   pb[1] = 2'd0;   pb[2] = 2'd2;
    send_pkt(3, -1, 1'b0, 0);
    @(negedge S_CLK) chk("lat_early", 64'(M_VALID), 64'(0));
    @(negedge S_CLK) chk("lat_first", 64'({M_VALID, M_DATA}), 64'({1'b1, 32'hA0}));
    @(negedge S_CLK) chk("b2b_1", 64'({M_VALID, M_DATA}), 64'({1'b1, 32'hA1}));
    @(negedge S_CLK) chk("b2b_2", 64'({M_VALID, M_LAST, M_BYTES, M_DATA}),
                         64'({1'b1, 1'b1, 2'd2, 32'hA2}));
    drain("drain_lat");

    // abort without S_VALID after two beats, then a clean packet
    fill_rand(4);
    send_pkt(4, 2, 1'b0, 0);
    pd[0] = 32'hB0; pd[1] = 32'hB1; pb[0] = 2'd1; pb[1] = 2'd3;
    send_pkt(2, -1, 1'b0, 0);
    drain("drain_abort");
    check_stats("abort");

    // 20-beat packet into an empty buffer
    stalls = 0;
    fill_rand(20);
    send_pkt(20, -1, 1'b0, 0);
    chk("oversize_no_stall", 64'(stalls), 64'(0));
    pd[0] = 32'hC0; pb[0] = 2'd0;
    send_pkt(1, -1, 1'b0, 0);
    drain("drain_oversize");
    check_stats("oversize");

    // fill the buffer with the reader stalled
    rd_mode = 0;
    tick();
    stalls = 0;
    s_first = 0;
    s_third = 0;
    fork
      begin
        for (int p = 0; p < 3; p++) begin
          if (p == 2) s_first = stalls;
          fill_rand(8);
          send_pkt(8, -1, 1'b0, 0);
        end
        s_third = stalls - s_first;
      end
      begin
        repeat (60) tick();
        rd_mode = 1;
      end
    join
    chk("fill_no_stall_first16", 64'(s_first), 64'(0));
    chk("fill_stall_third", 64'(s_third > 20), 64'(1));
    drain("drain_fill");

    // abort together with LAST discards the packet
    fill_rand(3);
    send_pkt(3, 2, 1'b1, 0);
    repeat (3) tick();
    chk("abort_last_wr", 64'(dut.wr_q), 64'(exp_wr));
    drain("drain_abort_last");
    check_stats("abort_last");

    // reset mid-packet with a beat parked in the output stage
    rd_mode = 0;
    tick();
    fill_rand(3);
    send_pkt(3, -1, 1'b0, 0);
    repeat (3) tick();
    chk("pre_reset_m_valid", 64'(M_VALID), 64'(1));
    fill_rand(2);
    send_beat(pd[0], pb[0], 1'b0, 1'b0);
    send_beat(pd[1], pb[1], 1'b0, 1'b0);
    do_reset(1);
    @(negedge S_CLK);
    check_reset_state();
    rd_mode = 1;
    tick();
    fill_rand(2);
    send_pkt(2, -1, 1'b0, 0);
    drain("drain_post_reset");

    // randomized traffic
    rd_mode = 2;
    for (int n = 0; n < 60; n++) begin
      int len, ab, sel;
      sel = $urandom_range(9);
      if (sel < 6)      len = $urandom_range(1, 10);
      else if (sel < 8) len = $urandom_range(11, DEPTH);
      else              len = $urandom_range(DEPTH + 1, DEPTH + 6);
      ab = -1;
      if (len >= 2 && len <= DEPTH && $urandom_range(99) < 20) ab = $urandom_range(1, len - 1);
      fill_rand(len);
      send_pkt(len, ab, 1'($urandom_range(1)), 20);
      if ($urandom_range(3) == 0) tick();
    end
    drain("drain_random");
    chk("random_wr_ptr", 64'(dut.wr_q), 64'(exp_wr));
    check_stats("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
